// File: rtl/mem2axi_if.sv
// mem2axi_if: AXI4 bus bundle used as the master port of mem2axi.
//   Parameters: AXI_ID_WIDTH, AXI_ADDR_WIDTH, AXI_DATA_WIDTH, AXI_USER_WIDTH.
//   Modports:
//     master - drives AW/W/AR payload and valids, plus b_ready/r_ready.
//     slave  - the mirror image, for a slave model or a downstream block.
// Handshake: a beat transfers on a rising clock edge where valid and ready are
// both 1. Once valid is raised, the source holds the payload stable and keeps
// valid high until that edge; ready may be raised or lowered freely.
interface mem2axi_if #(
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 10
);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]         w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/mem2axi.sv
// mem2axi: bridges a simple req/gnt memory port to single-beat AXI4
// transactions, one outstanding at a time.
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   req_i/gnt_o    - memory request / accepted this cycle
//   we_i, addr_i, be_i, data_i - request payload (write flag, byte address,
//                    byte enables, write data)
//   rvalid_o       - one-cycle completion pulse (reads and writes)
//   data_o, err_o  - read data / non-OKAY response, valid with rvalid_o
//   dbg_state_o    - current FSM state (IDLE=0, AR=1, R=2, AW_W=3, B=4)
//   master         - AXI4 master port (mem2axi_if.master)
module mem2axi #(
  parameter int                    AXI_ID_WIDTH   = 10,
  parameter int                    AXI_ADDR_WIDTH = 64,
  parameter int                    AXI_DATA_WIDTH = 64,
  parameter int                    AXI_USER_WIDTH = 10,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID       = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   data_i,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   data_o,
  output logic                        err_o,
  output logic [2:0]                  dbg_state_o,
  mem2axi_if.master                   master
);
  localparam int LOG_NR_BYTES = $clog2(AXI_DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW_W = 3'd3,
    B    = 3'd4
  } state_t;

  state_t                      r_state;
  logic [AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [AXI_DATA_WIDTH/8-1:0] r_be;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata;
  logic                        r_aw_done;
  logic                        r_w_done;
  logic                        r_rvalid;
  logic                        r_err;
  logic [AXI_DATA_WIDTH-1:0]   r_rdata;

  logic [AXI_ADDR_WIDTH-1:0]   w_axi_addr;
  logic                        w_aw_hs;
  logic                        w_w_hs;
  logic                        w_unused;

  // Beat-aligned address: single-beat transfers always start on a bus word.
  assign w_axi_addr = {r_addr[AXI_ADDR_WIDTH-1:LOG_NR_BYTES], {LOG_NR_BYTES{1'b0}}};

  // Valids/readies are gated by rst_i so nothing handshakes during the reset
  // cycle even though r_state only returns to IDLE at the next edge.
  assign gnt_o            = (r_state == IDLE) && req_i && !rst_i;
  assign master.ar_valid  = (r_state == AR) && !rst_i;
  assign master.r_ready   = (r_state == R) && !rst_i;
  assign master.aw_valid  = (r_state == AW_W) && !r_aw_done && !rst_i;
  assign master.w_valid   = (r_state == AW_W) && !r_w_done && !rst_i;
  assign master.b_ready   = (r_state == B) && !rst_i;

  assign w_aw_hs = master.aw_valid && master.aw_ready;
  assign w_w_hs  = master.w_valid && master.w_ready;

  assign master.ar_id     = AXI_ID;
  assign master.ar_addr   = w_axi_addr;
  assign master.ar_len    = 8'd0;
  assign master.ar_size   = 3'(LOG_NR_BYTES);
  assign master.ar_burst  = 2'b01;
  assign master.ar_lock   = 1'b0;
  assign master.ar_cache  = 4'd0;
  assign master.ar_prot   = 3'd0;
  assign master.ar_qos    = 4'd0;
  assign master.ar_region = 4'd0;
  assign master.ar_user   = '0;

  assign master.aw_id     = AXI_ID;
  assign master.aw_addr   = w_axi_addr;
  assign master.aw_len    = 8'd0;
  assign master.aw_size   = 3'(LOG_NR_BYTES);
  assign master.aw_burst  = 2'b01;
  assign master.aw_lock   = 1'b0;
  assign master.aw_cache  = 4'd0;
  assign master.aw_prot   = 3'd0;
  assign master.aw_qos    = 4'd0;
  assign master.aw_region = 4'd0;
  assign master.aw_user   = '0;

  assign master.w_data    = r_wdata;
  assign master.w_strb    = r_be;
  assign master.w_last    = 1'b1;
  assign master.w_user    = '0;

  assign rvalid_o    = r_rvalid;
  assign data_o      = r_rdata;
  assign err_o       = r_err;
  assign dbg_state_o = r_state;

  // Response IDs, user fields, r_last and the sub-word address bits carry no
  // information for a single-beat, single-ID bridge.
  assign w_unused = ^{master.b_id, master.b_user, master.r_id, master.r_last,
                      master.r_user, r_addr[LOG_NR_BYTES-1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_i) begin
            r_addr    <= addr_i;
            r_be      <= be_i;
            r_wdata   <= data_i;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= we_i ? AW_W : AR;
          end
        end
        AR: begin
          if (master.ar_ready) r_state <= R;
        end
        R: begin
          if (master.r_valid) begin
            r_rdata  <= master.r_data;
            r_err    <= (master.r_resp != 2'b00);
            r_rvalid <= 1'b1;
            r_state  <= IDLE;
          end
        end
        AW_W: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          // Combine the sticky flags with this cycle's handshakes so a
          // simultaneous AW+W handshake still moves on immediately.
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) r_state <= B;
        end
        B: begin
          if (master.b_valid) begin
            r_err    <= (master.b_resp != 2'b00);
            r_rvalid <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem2axi.sv
module tb_mem2axi;
  logic        clk;
  logic        rst;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [63:0] addr_i;
  logic [7:0]  be_i;
  logic [63:0] data_i;
  logic        rvalid_o;
  logic [63:0] data_o;
  logic        err_o;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  mem2axi_if bus ();

  mem2axi dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .be_i        (be_i),
    .data_i      (data_i),
    .rvalid_o    (rvalid_o),
    .data_o      (data_o),
    .err_o       (err_o),
    .dbg_state_o (dbg_state),
    .master      (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Zero-wait read; expected data travels through the scoreboard queue.
  task automatic read_txn(input string tag, input logic [63:0] addr,
                          input logic [63:0] rdata, input logic [1:0] resp);
    req_i = 1'b1; we_i = 1'b0; addr_i = addr;
    #1;
    chk({tag, "_gnt"}, gnt_o, 1);
    exp_q.push_back(rdata);
    tick();
    req_i = 1'b0; bus.ar_ready = 1'b1;
    #1;
    chk({tag, "_arvalid"}, bus.ar_valid, 1);
    chk({tag, "_araddr"}, bus.ar_addr, addr & ~64'h7);
    chk({tag, "_gnt_busy"}, gnt_o, 0);
    tick();
    bus.ar_ready = 1'b0; bus.r_valid = 1'b1; bus.r_data = rdata; bus.r_resp = resp;
    #1;
    chk({tag, "_rready"}, bus.r_ready, 1);
    chk({tag, "_arvalid_off"}, bus.ar_valid, 0);
    chk({tag, "_rvalid_early"}, rvalid_o, 0);
    tick();
    bus.r_valid = 1'b0;
    #1;
    chk({tag, "_rvalid"}, rvalid_o, 1);
    chk({tag, "_data"}, data_o, exp_q.pop_front());
    chk({tag, "_err"}, err_o, (resp != 2'b00));
    tick();
    #1;
    chk({tag, "_rvalid_pulse"}, rvalid_o, 0);
  endtask

  initial begin
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; data_i = '0;
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
    bus.b_valid = 1'b0; bus.b_resp = 2'b00; bus.b_id = '0; bus.b_user = '0;
    bus.r_valid = 1'b0; bus.r_resp = 2'b00; bus.r_id = '0; bus.r_user = '0;
    bus.r_last = 1'b1; bus.r_data = '0;
    repeat (2) tick();
    // reset state
    chk("rst_state", dbg_state, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_arvalid", bus.ar_valid, 0);
    chk("rst_awvalid", bus.aw_valid, 0);
    chk("rst_wvalid", bus.w_valid, 0);
    rst = 1'b0;
    tick();

    // read, zero-wait, OKAY
    read_txn("rd_ok", 64'h1004, 64'hDEADBEEF_CAFEF00D, 2'b00);
    chk("rd_ok_arlen", bus.ar_len, 0);
    chk("rd_ok_arsize", bus.ar_size, 3);
    chk("rd_ok_arburst", bus.ar_burst, 1);

    // write with AW ready at cycle 1, W ready delayed to cycle 4
    req_i = 1'b1; we_i = 1'b1; addr_i = 64'h2008; be_i = 8'h0F;
    data_i = 64'h11223344_55667788;
    #1;
    chk("wr_gnt", gnt_o, 1);
    tick();
    req_i = 1'b0; bus.aw_ready = 1'b1;
    #1;
    chk("wr_c1_state", dbg_state, 3);
    chk("wr_c1_awvalid", bus.aw_valid, 1);
    chk("wr_c1_awaddr", bus.aw_addr, 64'h2008);
    chk("wr_c1_wvalid", bus.w_valid, 1);
    chk("wr_c1_wstrb", bus.w_strb, 8'h0F);
    chk("wr_c1_wdata", bus.w_data, 64'h11223344_55667788);
    chk("wr_c1_wlast", bus.w_last, 1);
    tick();
    bus.aw_ready = 1'b0;
    #1;
    chk("wr_c2_awvalid", bus.aw_valid, 0);
    chk("wr_c2_wvalid", bus.w_valid, 1);
    tick();
    #1;
    chk("wr_c3_awvalid", bus.aw_valid, 0);
    chk("wr_c3_wvalid", bus.w_valid, 1);
    tick();
    bus.w_ready = 1'b1;
    #1;
    chk("wr_c4_wvalid", bus.w_valid, 1);
    chk("wr_c4_wstrb", bus.w_strb, 8'h0F);
    tick();
    bus.w_ready = 1'b0; bus.b_valid = 1'b1; bus.b_resp = 2'b00;
    #1;
    chk("wr_c5_state", dbg_state, 4);
    chk("wr_c5_wvalid", bus.w_valid, 0);
    chk("wr_c5_bready", bus.b_ready, 1);
    chk("wr_c5_rvalid", rvalid_o, 0);
    tick();
    bus.b_valid = 1'b0;
    #1;
    chk("wr_rvalid", rvalid_o, 1);
    chk("wr_err", err_o, 0);
    chk("wr_data_kept", data_o, 64'hDEADBEEF_CAFEF00D);
    tick();
    #1;
    chk("wr_rvalid_pulse", rvalid_o, 0);

    // read with SLVERR
    read_txn("rd_slverr", 64'h4010, 64'h0BAD_0BAD_0BAD_0BAD, 2'b10);

    // zero-wait write with DECERR, AW and W in the same cycle
    req_i = 1'b1; we_i = 1'b1; addr_i = 64'h5000; be_i = 8'hFF; data_i = 64'hA5A5;
    #1;
    chk("wd_gnt", gnt_o, 1);
    tick();
    req_i = 1'b0; bus.aw_ready = 1'b1; bus.w_ready = 1'b1;
    #1;
    chk("wd_awvalid", bus.aw_valid, 1);
    chk("wd_wvalid", bus.w_valid, 1);
    tick();
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.b_valid = 1'b1; bus.b_resp = 2'b11;
    #1;
    chk("wd_state_b", dbg_state, 4);
    chk("wd_bready", bus.b_ready, 1);
    tick();
    bus.b_valid = 1'b0; bus.b_resp = 2'b00;
    #1;
    chk("wd_rvalid", rvalid_o, 1);
    chk("wd_err", err_o, 1);
    tick();

    // back-to-back reads with req_i held high
    req_i = 1'b1; we_i = 1'b0; addr_i = 64'h3000;
    #1;
    chk("bb_gnt0", gnt_o, 1);
    tick();
    bus.ar_ready = 1'b1;
    #1;
    chk("bb_c1_gnt", gnt_o, 0);
    tick();
    bus.ar_ready = 1'b0; bus.r_valid = 1'b1; bus.r_data = 64'h1111_2222_3333_4444;
    bus.r_resp = 2'b00;
    #1;
    chk("bb_c2_gnt", gnt_o, 0);
    tick();
    bus.r_valid = 1'b0;
    #1;
    chk("bb_c3_rvalid", rvalid_o, 1);
    chk("bb_c3_gnt", gnt_o, 1);
    chk("bb_c3_data", data_o, 64'h1111_2222_3333_4444);
    tick();
    req_i = 1'b0; bus.ar_ready = 1'b1;
    #1;
    chk("bb_c4_arvalid", bus.ar_valid, 1);
    chk("bb_c4_gnt", gnt_o, 0);
    chk("bb_c4_rvalid", rvalid_o, 0);
    tick();
    bus.ar_ready = 1'b0; bus.r_valid = 1'b1; bus.r_data = 64'h5555_6666_7777_8888;
    #1;
    tick();
    bus.r_valid = 1'b0;
    #1;
    chk("bb_2nd_rvalid", rvalid_o, 1);
    chk("bb_2nd_data", data_o, 64'h5555_6666_7777_8888);
    tick();

    // reset asserted while in R
    req_i = 1'b1; we_i = 1'b0; addr_i = 64'h6000;
    tick();
    req_i = 1'b0; bus.ar_ready = 1'b1;
    tick();
    bus.ar_ready = 1'b0;
    #1;
    chk("rr_in_r", dbg_state, 2);
    rst = 1'b1;
    #1;
    chk("rr_rready_rst", bus.r_ready, 0);
    tick();
    rst = 1'b0;
    bus.r_valid = 1'b1; bus.r_data = 64'hFFFF_0000_FFFF_0000;
    #1;
    chk("rr_state", dbg_state, 0);
    chk("rr_rready", bus.r_ready, 0);
    chk("rr_rvalid", rvalid_o, 0);
    chk("rr_data", data_o, 0);
    tick();
    bus.r_valid = 1'b0;
    #1;
    chk("rr_rvalid_late", rvalid_o, 0);
    read_txn("rd_after_rst", 64'h7007, 64'h0123_4567_89AB_CDEF, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem2axi.md
MEM2AXI -- requirements
Module: mem2axi

Interface
REQ-001 AXI_ID_WIDTH, 10, width of AXI ID fields.
REQ-002 AXI_ADDR_WIDTH, 64, width of memory and AXI addresses.
REQ-003 AXI_DATA_WIDTH, 64, data width; LOG_NR_BYTES = log2(AXI_DATA_WIDTH/8).
REQ-004 AXI_USER_WIDTH, 10, width of AXI user fields.
REQ-005 AXI_ID, 0, constant ID driven on aw_id and ar_id.
REQ-006 clk_i  input  1  single clock; all logic is on the rising edge.
REQ-007 rst_i  input  1  reset, synchronous and active-high.
REQ-008 req_i  input  1  memory-side request valid.
REQ-009 gnt_o  output  1  request accepted this cycle.
REQ-010 we_i  input  1  1 = write, 0 = read.
REQ-011 addr_i  input  AXI_ADDR_WIDTH  byte address.
REQ-012 be_i  input  AXI_DATA_WIDTH/8  write byte enables.
REQ-013 data_i  input  AXI_DATA_WIDTH  write data.
REQ-014 rvalid_o  output  1  one-cycle completion pulse for reads and writes.
REQ-015 data_o  output  AXI_DATA_WIDTH  read data, valid with rvalid_o.
REQ-016 err_o  output  1  completion carried a non-OKAY response; valid with rvalid_o.
REQ-017 master  AXI_BUS.Master  -  AXI4 master port.

Function
REQ-018 The block SHALL bridge one memory request to one single-beat AXI transaction, with at most one transaction outstanding.
REQ-019 States SHALL be IDLE, AR, R, AW_W and B.
REQ-020 In IDLE, gnt_o SHALL equal req_i; gnt_o SHALL be 0 in every other state.
REQ-021 On grant, addr_i, we_i, be_i and data_i SHALL be registered. The next state SHALL be AW_W if we_i is 1, else AR.
REQ-022 In AR, ar_valid SHALL be 1 and ar_addr SHALL be the registered address with bits [LOG_NR_BYTES-1:0] forced to 0.
REQ-023 In AR: ar_len=0, ar_size=LOG_NR_BYTES, ar_burst=INCR, ar_id=AXI_ID, and all other AR attributes SHALL be 0. On ar_ready the state SHALL move to R.
REQ-024 In R, r_ready SHALL be 1. On r_valid the block SHALL register r_data into data_o, register (r_resp!=0) into err_o, and return to IDLE.
REQ-025 In AW_W, aw_valid and w_valid SHALL be asserted independently until each handshakes.
REQ-026 AW attributes SHALL match REQ-022/023. On the W channel: w_data=registered data, w_strb=registered be, w_last=1.
REQ-027 Two sticky flags SHALL record completed AW and W handshakes. The state SHALL move to B in the cycle both are done, including the case where both complete in the same cycle.
REQ-028 AW/W valids SHALL NOT deassert before their own handshake, and SHALL NOT reassert after it.
REQ-029 In B, b_ready SHALL be 1. On b_valid the block SHALL register (b_resp!=0) into err_o, leave data_o unchanged, and return to IDLE.
REQ-030 rvalid_o SHALL pulse high for exactly the cycle after the R or B handshake.
REQ-031 Since the state returns to IDLE on that handshake, a new grant SHALL be possible in the same cycle rvalid_o is high.
REQ-032 Minimum latency with zero-wait slave: read grant at cycle 0, ar handshake cycle 1, r handshake cycle 2, rvalid_o cycle 3.
REQ-033 Minimum write latency: grant cycle 0, aw+w handshake cycle 1, b handshake cycle 2, rvalid_o cycle 3.
REQ-034 r_last SHALL be ignored.
REQ-035 User fields SHALL be driven 0.
REQ-036 Sticky flags SHALL be cleared on grant.

Reset
REQ-037 When rst_i is high at a clock edge, the state SHALL become IDLE, and the sticky flags, rvalid_o, err_o and data_o SHALL become 0.
REQ-038 While in reset, all AXI valid/ready outputs SHALL be 0.
REQ-039 Reset mid-transaction SHALL abandon the transaction; no rvalid_o pulse SHALL follow for it.

Verification
REQ-040 Read, zero-wait slave, addr_i=0x1004, slave returns 0xDEADBEEF_CAFEF00D OKAY -> ar_addr=0x1000, ar_len=0; rvalid_o at cycle 3; data_o=0xDEADBEEF_CAFEF00D; err_o=0.
REQ-041 Write with be_i=0x0F and data_i=0x11223344_55667788; AW ready at cycle 1, W ready delayed to cycle 4 -> aw_valid drops after cycle 1; w_valid held through cycle 4 with w_strb=0x0F, w_last=1; B accepted; rvalid_o pulses once.
REQ-042 Read with r_resp=SLVERR -> rvalid_o=1 and err_o=1.
REQ-043 Write with b_resp=DECERR -> rvalid_o=1 and err_o=1.
REQ-044 Back-to-back requests with req_i held high -> second gnt_o in the same cycle as the first rvalid_o; never two transactions outstanding.
REQ-045 rst_i asserted while in R -> next cycle: state IDLE, r_ready=0, no rvalid_o; a subsequent read completes normally.
